// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// FSM state encoding, opcode/funct values, ALU codes and mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: maps funct to an ALU code and flags unsupported
// funct values. Ports: funct in; aluOp, valid out.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluOp,
    output logic       valid
);

    always_comb begin
        aluOp = ALU_ADD;
        valid = 1'b1;
        case (funct)
            FN_ADD:  aluOp = ALU_ADD;
            FN_SUB:  aluOp = ALU_SUB;
            FN_AND:  aluOp = ALU_AND;
            FN_OR:   aluOp = ALU_OR;
            FN_SLT:  aluOp = ALU_SLT;
            FN_SLL:  aluOp = ALU_SLL;
            FN_SRL:  aluOp = ALU_SRL;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath. Inputs: clk, rst, opcode,
// funct, zero, memReady. Outputs: datapath selects/enables, illegal, retired.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memReady,
    output logic             pcEn,
    output logic [1:0]       pcSrc,
    output logic             iorD,
    output logic             memWriteEn,
    output logic             irWrite,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluOp,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    state_t     next;
    logic       is_sw;
    logic       is_bne;
    logic [2:0] fn_op;
    logic       fn_ok;
    logic       retire;

    alu_decoder u_alu_dec (
        .funct (funct),
        .aluOp (fn_op),
        .valid (fn_ok)
    );

    // Opcode is only trusted in DECODE, so the lw/sw and beq/bne choice
    // is captured there for use in MEMADR and BRANCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_START;
            is_sw   <= 1'b0;
            is_bne  <= 1'b0;
            retired <= '0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                is_sw  <= (opcode == OP_SW);
                is_bne <= (opcode == OP_BNE);
            end
            if (retire)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = memReady;
            default: retire = 1'b0;
        endcase
    end

    always_comb begin
        next = state;
        case (state)
            S_START: next = S_FETCH;
            S_FETCH: next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       next = S_EXEC;
                    OP_LW, OP_SW:   next = S_MEMADR;
                    OP_BEQ, OP_BNE: next = S_BRANCH;
                    OP_ADDI:        next = S_ADDIEX;
                    OP_J:           next = S_JUMP;
                    default:        next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: next = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next = S_FETCH;
            S_MEMWR:  next = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   next = fn_ok ? S_ALUWB : S_ILLEGAL;
            S_ALUWB:  next = S_FETCH;
            S_BRANCH: next = S_FETCH;
            S_ADDIEX: next = S_ADDIWB;
            S_ADDIWB: next = S_FETCH;
            S_JUMP:   next = S_FETCH;
            S_ILLEGAL: next = S_ILLEGAL;
            default:  next = S_START;
        endcase
    end

    always_comb begin
        pcEn       = 1'b0;
        pcSrc      = PC_ALU;
        iorD       = 1'b0;
        memWriteEn = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = SRCB_RT;
        aluOp      = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                aluSrcB = SRCB_FOUR;
                irWrite = memReady;
                pcEn    = memReady;
            end
            S_DECODE: aluSrcB = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: iorD = 1'b1;
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                iorD       = 1'b1;
                memWriteEn = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = fn_op;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_SUB;
                pcSrc   = PC_ALUOUT;
                pcEn    = is_bne ? ~zero : zero;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_JUMP: begin
                pcSrc = PC_JUMP;
                pcEn  = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
